// File: rtl/fight_pkg.sv
// Shared encodings and damage tables for the fight backend.
// Health arithmetic saturates at zero so the bars never wrap.
package fight_pkg;

  typedef enum logic [1:0] {
    STANDBY  = 2'b00,
    LIGHT    = 2'b01,
    HEAVY    = 2'b10,
    TYPE_INV = 2'b11
  } atk_type_t;

  typedef enum logic [1:0] {
    NO_HIT   = 2'b00,
    CRITICAL = 2'b01,
    NORMAL   = 2'b10,
    MISS     = 2'b11
  } roll_t;

  typedef enum logic [1:0] {
    PH_IDLE    = 2'b00,
    PH_FIGHT   = 2'b01,
    PH_P1_WIN  = 2'b10,
    PH_CPU_WIN = 2'b11
  } phase_t;

  localparam logic [7:0] DMG_LIGHT_NORM = 8'd1;
  localparam logic [7:0] DMG_LIGHT_CRIT = 8'd2;
  localparam logic [7:0] DMG_HEAVY_NORM = 8'd2;
  localparam logic [7:0] DMG_HEAVY_CRIT = 8'd4;
  localparam logic [7:0] DMG_CPU_NORM   = 8'd5;
  localparam logic [7:0] DMG_CPU_CRIT   = 8'd6;

  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : 8'd0;
  endfunction

  function automatic logic [7:0] p1_damage(input logic [1:0] typ, input logic [1:0] roll);
    logic [7:0] dmg;
    dmg = 8'd0;
    if (typ == LIGHT) begin
      if (roll == CRITICAL) dmg = DMG_LIGHT_CRIT;
      else if (roll == NORMAL) dmg = DMG_LIGHT_NORM;
    end else if (typ == HEAVY) begin
      if (roll == CRITICAL) dmg = DMG_HEAVY_CRIT;
      else if (roll == NORMAL) dmg = DMG_HEAVY_NORM;
    end
    return dmg;
  endfunction

  function automatic logic [7:0] cpu_damage(input logic [1:0] roll);
    logic [7:0] dmg;
    dmg = 8'd0;
    if (roll == CRITICAL) dmg = DMG_CPU_CRIT;
    else if (roll == NORMAL) dmg = DMG_CPU_NORM;
    return dmg;
  endfunction

endpackage

// File: rtl/cpu_attack_timer.sv
// Modulo-PERIOD counter; o_expire pulses in the last count of each period.
// Clear has priority over enable so a round start always begins at zero.
module cpu_attack_timer #(
  parameter int PERIOD = 10_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expire
);

  localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [W-1:0] r_cnt;

  assign o_expire = i_en && !i_clr && (r_cnt == W'(PERIOD - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_expire ? '0 : r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/combat_scheduler.sv
// Round sequencer: phase FSM, player/CPU hit arbitration, cooldown and health.
// At most one hit is applied per cycle; the player wins ties, the CPU hit waits.
module combat_scheduler
  import fight_pkg::*;
#(
  parameter int START_HEALTH = 100,
  parameter int CPU_PERIOD   = 10_000_000,
  parameter int COOLDOWN     = 2_500_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       p1_req,
  input  logic [1:0] p1_type,
  input  logic [1:0] p1_roll,
  input  logic [1:0] cpu_roll,
  output logic [7:0] p1_health,
  output logic [7:0] cpu_health,
  output logic       cpu_attacking,
  output logic       p1_ack,
  output logic       p1_busy,
  output logic [1:0] phase
);

  localparam int         CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [7:0] HP0  = 8'(START_HEALTH);

  phase_t          r_phase, w_phase_nxt;
  logic [CD_W-1:0] r_cd;
  logic            r_pending, r_attacking, r_ack;
  logic [7:0]      r_p1_hp, r_cpu_hp;
  logic            w_fight, w_start_round, w_accept, w_cpu_apply, w_expire;
  logic [7:0]      w_cpu_hp_nxt, w_p1_hp_nxt, w_cpu_dmg;

  assign w_fight       = (r_phase == PH_FIGHT);
  assign w_start_round = start && !w_fight;
  assign w_accept      = w_fight && p1_req && (r_cd == '0) &&
                         ((p1_type == LIGHT) || (p1_type == HEAVY));
  assign w_cpu_apply   = w_fight && r_pending && !w_accept;
  assign w_cpu_dmg     = cpu_damage(cpu_roll);
  assign w_cpu_hp_nxt  = sat_sub(r_cpu_hp, p1_damage(p1_type, p1_roll));
  assign w_p1_hp_nxt   = sat_sub(r_p1_hp, w_cpu_dmg);

  cpu_attack_timer #(.PERIOD(CPU_PERIOD)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_en     (w_fight),
    .i_clr    (w_start_round),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_phase <= PH_IDLE;
    else          r_phase <= w_phase_nxt;
  end

  // Round end is judged on the health value being written this cycle.
  always_comb begin
    w_phase_nxt = r_phase;
    case (r_phase)
      PH_FIGHT: begin
        if (w_accept && (w_cpu_hp_nxt == 8'd0))         w_phase_nxt = PH_P1_WIN;
        else if (w_cpu_apply && (w_p1_hp_nxt == 8'd0))  w_phase_nxt = PH_CPU_WIN;
      end
      default: begin
        if (start) w_phase_nxt = PH_FIGHT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_p1_hp     <= HP0;
      r_cpu_hp    <= HP0;
      r_cd        <= '0;
      r_pending   <= 1'b0;
      r_attacking <= 1'b0;
      r_ack       <= 1'b0;
    end else if (w_start_round) begin
      r_p1_hp     <= HP0;
      r_cpu_hp    <= HP0;
      r_cd        <= '0;
      r_pending   <= 1'b0;
      r_attacking <= 1'b0;
      r_ack       <= 1'b0;
    end else begin
      r_ack <= w_accept;
      if (w_accept)          r_cd <= CD_W'(COOLDOWN);
      else if (r_cd != '0)   r_cd <= r_cd - CD_W'(1);
      if (w_accept) r_cpu_hp <= w_cpu_hp_nxt;
      if (w_cpu_apply) begin
        r_p1_hp     <= w_p1_hp_nxt;
        r_attacking <= (w_cpu_dmg != 8'd0);
      end
      // A pending CPU hit never survives into an end phase.
      if (!w_fight || (w_phase_nxt != PH_FIGHT)) r_pending <= 1'b0;
      else if (w_expire)                         r_pending <= 1'b1;
      else if (w_cpu_apply)                      r_pending <= 1'b0;
    end
  end

  assign p1_health     = r_p1_hp;
  assign cpu_health    = r_cpu_hp;
  assign cpu_attacking = r_attacking;
  assign p1_ack        = r_ack;
  assign p1_busy       = (r_cd != '0);
  assign phase         = r_phase;

endmodule

// File: tb/tb_combat_scheduler.sv
// Directed bench for combat_scheduler with CPU_PERIOD=8, COOLDOWN=4.
// Inputs change 1 ns after a rising edge; outputs are checked there too.
module tb_combat_scheduler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       p1_req;
  logic [1:0] p1_type;
  logic [1:0] p1_roll;
  logic [1:0] cpu_roll;
  logic [7:0] p1_health;
  logic [7:0] cpu_health;
  logic       cpu_attacking;
  logic       p1_ack;
  logic       p1_busy;
  logic [1:0] phase;

  int n_total = 0;
  int n_bad   = 0;

  combat_scheduler #(
    .START_HEALTH (100),
    .CPU_PERIOD   (8),
    .COOLDOWN     (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .p1_req        (p1_req),
    .p1_type       (p1_type),
    .p1_roll       (p1_roll),
    .cpu_roll      (cpu_roll),
    .p1_health     (p1_health),
    .cpu_health    (cpu_health),
    .cpu_attacking (cpu_attacking),
    .p1_ack        (p1_ack),
    .p1_busy       (p1_busy),
    .phase         (phase)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic [1:0] typ, input logic [1:0] roll);
    p1_req  = 1'b1;
    p1_type = typ;
    p1_roll = roll;
  endtask

  task automatic wait_not_busy();
    int k;
    k = 0;
    while (p1_busy && k < 10) begin
      step();
      k++;
    end
    chk("busy_clears", {31'd0, p1_busy}, 32'd0);
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    p1_req   = 1'b0;
    p1_type  = 2'b00;
    p1_roll  = 2'b00;
    cpu_roll = 2'b11;
    step(); step();
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_p1_hp", 32'(p1_health), 32'd100);
    chk("rst_cpu_hp", 32'(cpu_health), 32'd100);
    chk("rst_att", 32'(cpu_attacking), 32'd0);
    chk("rst_ack", 32'(p1_ack), 32'd0);
    chk("rst_busy", 32'(p1_busy), 32'd0);
    reset_n = 1'b1;
    step(); step();
    chk("idle_hold", 32'(phase), 32'd0);

    // start -> FIGHT at edge S
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_phase", 32'(phase), 32'd1);
    chk("start_p1_hp", 32'(p1_health), 32'd100);
    chk("start_cpu_hp", 32'(cpu_health), 32'd100);

    // heavy critical, then a dropped request during cooldown
    drive_req(2'b10, 2'b01);
    step();                                   // S+1
    p1_req = 1'b0;
    chk("hc_cpu_hp", 32'(cpu_health), 32'd96);
    chk("hc_ack", 32'(p1_ack), 32'd1);
    chk("hc_busy1", 32'(p1_busy), 32'd1);
    step();                                   // S+2
    chk("hc_ack_pulse", 32'(p1_ack), 32'd0);
    chk("hc_busy2", 32'(p1_busy), 32'd1);
    drive_req(2'b10, 2'b01);
    step();                                   // S+3
    p1_req = 1'b0;
    chk("drop_cpu_hp", 32'(cpu_health), 32'd96);
    chk("drop_ack", 32'(p1_ack), 32'd0);
    chk("hc_busy3", 32'(p1_busy), 32'd1);
    step();                                   // S+4
    chk("hc_busy4", 32'(p1_busy), 32'd1);
    step();                                   // S+5
    chk("hc_busy_end", 32'(p1_busy), 32'd0);

    // CPU normal at wrap S+8 applies at S+9; miss at S+17
    cpu_roll = 2'b10;
    repeat (3) step();                        // S+8
    chk("cpu_before_apply", 32'(p1_health), 32'd100);
    step();                                   // S+9
    chk("cpu_norm_hp", 32'(p1_health), 32'd95);
    chk("cpu_norm_att", 32'(cpu_attacking), 32'd1);
    cpu_roll = 2'b11;
    repeat (7) step();                        // S+16
    chk("cpu_period_hold", 32'(cpu_attacking), 32'd1);
    step();                                   // S+17
    chk("cpu_miss_hp", 32'(p1_health), 32'd95);
    chk("cpu_miss_att", 32'(cpu_attacking), 32'd0);

    // player hit in the cycle cpu_pending is set (after wrap S+24)
    cpu_roll = 2'b01;
    repeat (7) step();                        // S+24
    drive_req(2'b01, 2'b10);
    step();                                   // S+25
    p1_req = 1'b0;
    chk("sim_cpu_hp", 32'(cpu_health), 32'd95);
    chk("sim_p1_first", 32'(p1_health), 32'd95);
    chk("sim_ack", 32'(p1_ack), 32'd1);
    step();                                   // S+26
    chk("sim_p1_hp", 32'(p1_health), 32'd89);
    chk("sim_att", 32'(cpu_attacking), 32'd1);

    // invalid and standby types are dropped
    cpu_roll = 2'b11;
    wait_not_busy();
    drive_req(2'b11, 2'b01);
    step();
    chk("inv_ack", 32'(p1_ack), 32'd0);
    drive_req(2'b00, 2'b01);
    step();
    p1_req = 1'b0;
    chk("stby_ack", 32'(p1_ack), 32'd0);
    chk("stby_cpu_hp", 32'(cpu_health), 32'd95);
    chk("stby_busy", 32'(p1_busy), 32'd0);

    // drain CPU to 3 with 23 heavy criticals, then saturate to 0
    for (int i = 0; i < 23; i++) begin
      wait_not_busy();
      drive_req(2'b10, 2'b01);
      step();
      p1_req = 1'b0;
    end
    chk("drain_cpu_hp", 32'(cpu_health), 32'd3);
    chk("drain_phase", 32'(phase), 32'd1);
    chk("drain_p1_hp", 32'(p1_health), 32'd89);
    wait_not_busy();
    drive_req(2'b10, 2'b01);
    step();
    chk("sat_cpu_hp", 32'(cpu_health), 32'd0);
    chk("win_phase", 32'(phase), 32'd2);
    chk("win_ack", 32'(p1_ack), 32'd1);

    // end phase: requests and CPU expiries change nothing
    cpu_roll = 2'b10;
    repeat (20) step();
    p1_req = 1'b0;
    chk("end_cpu_hp", 32'(cpu_health), 32'd0);
    chk("end_p1_hp", 32'(p1_health), 32'd89);
    chk("end_phase", 32'(phase), 32'd2);
    chk("end_ack", 32'(p1_ack), 32'd0);

    start = 1'b1;
    step();                                   // R
    start = 1'b0;
    chk("restart_phase", 32'(phase), 32'd1);
    chk("restart_cpu_hp", 32'(cpu_health), 32'd100);
    chk("restart_p1_hp", 32'(p1_health), 32'd100);

    // reset with cooldown active and a CPU hit pending (wrap at R+8)
    cpu_roll = 2'b11;
    repeat (7) step();                        // R+7
    drive_req(2'b10, 2'b10);
    step();                                   // R+8
    p1_req = 1'b0;
    chk("pre_rst_cpu_hp", 32'(cpu_health), 32'd98);
    chk("pre_rst_busy", 32'(p1_busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_phase", 32'(phase), 32'd0);
    chk("mid_rst_cpu_hp", 32'(cpu_health), 32'd100);
    chk("mid_rst_p1_hp", 32'(p1_health), 32'd100);
    chk("mid_rst_busy", 32'(p1_busy), 32'd0);
    chk("mid_rst_ack", 32'(p1_ack), 32'd0);
    chk("mid_rst_att", 32'(cpu_attacking), 32'd0);
    step();
    reset_n  = 1'b1;
    cpu_roll = 2'b10;
    repeat (20) step();
    chk("post_rst_p1_hp", 32'(p1_health), 32'd100);
    chk("post_rst_phase", 32'(phase), 32'd0);
    chk("post_rst_att", 32'(cpu_attacking), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("post_rst_start", 32'(phase), 32'd1);

    // final report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/combat_scheduler.md
# combat_scheduler

Round-level sequencer for the fight backend. It owns both health registers and runs the round phase machine. It generates the CPU attack cadence and arbitrates player and CPU hits onto a single damage-apply path, at most one hit per cycle. It sits between keyboard decode and the LFSR roll generators (upstream) and the display/health bars (downstream).

## Interface
- `START_HEALTH`, default 100: health loaded on reset and at each round start.
- `CPU_PERIOD`, default 10_000_000: cycles between CPU attack attempts (1 s at 10 MHz); must be ≥ 2.
- `COOLDOWN`, default 2_500_000: cycles the player is locked out after an accepted attack; 0 disables the lockout.
- `clk` in 1: single clock, 10 MHz, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; starts a round from IDLE, P1_WIN or CPU_WIN.
- `p1_req` in 1: one-cycle player attack request.
- `p1_type` in 2: 00 standby, 01 light, 10 heavy, 11 invalid (treated as standby).
- `p1_roll` in 2: player LFSR state: 00 no-hit, 01 critical, 10 normal, 11 miss.
- `cpu_roll` in 2: CPU LFSR state, same encoding as `p1_roll`.
- `p1_health` out 8: player health.
- `cpu_health` out 8: CPU health.
- `cpu_attacking` out 1: level; high while the last applied CPU attack landed.
- `p1_ack` out 1: one-cycle pulse when a player attack is applied.
- `p1_busy` out 1: player cooldown active.
- `phase` out 2: 00 IDLE, 01 FIGHT, 10 P1_WIN, 11 CPU_WIN.

## Operation
- Reset values:
  - `phase` = IDLE.
  - Both healths = START_HEALTH.
  - `cpu_attacking`, `p1_ack` and `p1_busy` = 0.
  - Cooldown counter, CPU timer and `cpu_pending` cleared.
- `start` handling:
  - In IDLE, P1_WIN or CPU_WIN: go to FIGHT, reload both healths, clear the timer, cooldown, `cpu_pending` and `cpu_attacking`.
  - In FIGHT: `start` is ignored.
- Player acceptance: `p1_req` is accepted only when all of these hold:
  - `phase` is FIGHT.
  - `p1_busy` is 0.
  - `p1_type` is light or heavy.
  
  Any other request is dropped silently, with no ack and no queueing.
- `p1_roll` is sampled in the same cycle as the accepted `p1_req`.
- Player damage to the CPU:
  - Light: critical 2, normal 1.
  - Heavy: critical 4, normal 2.
  - Miss or no-hit: 0. The attack is still acked and still starts the cooldown.
- CPU timer:
  - Runs only in FIGHT; frozen in all other phases.
  - Counts 0..CPU_PERIOD-1, then wraps to 0 and sets `cpu_pending`.
  - An expiry while `cpu_pending` is already set does not stack a second attack.
- CPU damage to the player:
  - Applied when `cpu_pending` is set and the apply path is free.
  - `cpu_roll` is sampled in the apply cycle.
  - Critical 6, normal 5; `cpu_attacking` goes to 1.
  - Miss or no-hit: 0; `cpu_attacking` goes to 0.
  - `cpu_pending` clears on apply.
- Arbitration: an accepted player attack and a pending CPU attack in the same cycle are resolved by applying the player attack first. The CPU attack stays pending and applies in the next cycle, unless the round ends first.
- Arithmetic: 8-bit subtraction saturating at 0; health never wraps.
- Round end (evaluated on the updated value):
  - `cpu_health` reaching 0 → P1_WIN.
  - `p1_health` reaching 0 → CPU_WIN.
  
  One apply per cycle means both cannot reach 0 in the same cycle. In the end phases, healths hold, requests are dropped, the timer freezes and `cpu_pending` is discarded.
- Cooldown:
  - Loads COOLDOWN on each accepted request and decrements to 0.
  - `p1_busy` = (counter ≠ 0).

## Timing
- All outputs are registered.
- Accepted `p1_req` in cycle N:
  - `cpu_health` updates and `p1_ack` pulses after edge N+1.
  - `p1_busy` is high from N+1 for exactly COOLDOWN cycles.
- CPU timer wrap at edge T:
  - `cpu_pending` is set after edge T.
  - Health applies after edge T+1, or T+2 if a player attack takes that slot.
- Phase change after the same edge that writes the zero health.
- Asynchronous `reset_n` assertion mid-round forces all reset values immediately. The first round starts only on `start` after reset release.

## Structure
- Shared package `fight_pkg` holds:
  - Attack type codes (STANDBY, LIGHT, HEAVY).
  - Roll codes (NO_HIT, CRITICAL, NORMAL, MISS).
  - Phase encodings.
  - The damage constants 1, 2, 4, 5, 6.
- Sub-module `cpu_attack_timer`: the modulo-CPU_PERIOD counter with enable and clear, producing a one-cycle `expire` pulse.
- The top level holds the phase FSM, arbitration, cooldown counter and saturating health update.

## Test plan
Bench parameters: CPU_PERIOD = 8, COOLDOWN = 4.
- **Reset, then start:** `phase` = 01, both healths 100, CPU timer expiry every 8 cycles.
- **Heavy critical:** `p1_req` with type 10, roll 01 → `cpu_health` 96 and one `p1_ack` pulse. A second `p1_req` 2 cycles later is dropped; `p1_busy` is high for 4 cycles.
- **CPU attacks:** CPU normal → `p1_health` 95, `cpu_attacking` = 1. Next CPU roll miss → health stays 95, `cpu_attacking` = 0.
- **Simultaneous events:** light normal `p1_req` in the cycle `cpu_pending` is set → `cpu_health` −1 at N+1, `p1_health` −6 (critical) at N+2.
- **Saturation and round end:** preload `cpu_health` to 3, apply heavy critical → `cpu_health` 0 and `phase` P1_WIN. Later timer expiries and requests change nothing; `start` restores both healths to 100.
- **Reset mid-operation:** assert `reset_n` low mid-round with `p1_busy` high and `cpu_pending` set → all outputs at reset values immediately. After release, no CPU attack occurs until `start`.
